// File: rtl/mic_pkg.sv
// Shared microphone-clock defaults and types, also used by the PDM decimator blocks.
package mic_pkg;

   localparam int unsigned DEF_DIV_W = 16;
   localparam int unsigned DEF_DEC_W = 8;
   localparam int unsigned DEF_HALF  = 20;
   localparam int unsigned DEF_DEC   = 64;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_RISE,
      EV_FALL
   } mic_edge_e;

endpackage

// File: rtl/mic_rise_counter.sv
// Counts mic-clock rises and pulses sample_stb on every reload_val+1-th rise.
module mic_rise_counter
   import mic_pkg::*;
#(
   parameter int unsigned DEC_W   = DEF_DEC_W,
   parameter int unsigned RST_VAL = DEF_DEC - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             rise,
   input  logic             reload,
   input  logic [DEC_W-1:0] reload_val,
   output logic             sample_stb
);

   logic [DEC_W-1:0] cnt_q, cnt_d;
   logic             stb_q, stb_d;

   // rise is the next-state rise strobe, so stb_q lines up with the registered rise_stb
   always_comb begin
      cnt_d = cnt_q;
      stb_d = 1'b0;
      if (!enable || reload) begin
         cnt_d = reload_val;
      end else if (rise) begin
         if (cnt_q == '0) begin
            stb_d = 1'b1;
            cnt_d = reload_val;
         end else begin
            cnt_d = cnt_q - DEC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= DEC_W'(RST_VAL);
         stb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         stb_q <= stb_d;
      end
   end

   assign sample_stb = stb_q;

endmodule

// File: rtl/mic_clk_gen.sv
// Programmable 50%-duty microphone clock with rise/fall/sample strobes.
// New settings loaded while running take effect only at a falling edge.
module mic_clk_gen #(
   parameter int unsigned DIV_W    = mic_pkg::DEF_DIV_W,
   parameter int unsigned DEC_W    = mic_pkg::DEF_DEC_W,
   parameter int unsigned DEF_HALF = mic_pkg::DEF_HALF,
   parameter int unsigned DEF_DEC  = mic_pkg::DEF_DEC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] half_in,
   input  logic [DEC_W-1:0] dec_in,
   output logic             clkout,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic             sample_stb,
   output logic             active
);
   import mic_pkg::*;

   logic [DIV_W-1:0] half_q, half_d, pend_half_q, pend_half_d, cnt_q, cnt_d;
   logic [DEC_W-1:0] dec_q, dec_d, pend_dec_q, pend_dec_d, dec_rel_val;
   logic             pend_v_q, pend_v_d;
   logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d, act_q;
   logic             dec_reload;
   logic [DIV_W-1:0] half_in_nz;
   logic [DEC_W-1:0] dec_in_nz;
   mic_edge_e        edge_kind;

   assign half_in_nz = (half_in == '0) ? DIV_W'(1) : half_in;
   assign dec_in_nz  = (dec_in == '0) ? DEC_W'(1) : dec_in;

   always_comb begin
      half_d      = half_q;
      dec_d       = dec_q;
      pend_half_d = pend_half_q;
      pend_dec_d  = pend_dec_q;
      pend_v_d    = pend_v_q;
      cnt_d       = cnt_q;
      clk_d       = clk_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      dec_reload  = 1'b0;
      edge_kind   = EV_NONE;
      if (!en) begin
         if (load) begin
            half_d = half_in_nz;
            dec_d  = dec_in_nz;
         end else if (pend_v_q) begin
            half_d = pend_half_q;
            dec_d  = pend_dec_q;
         end
         pend_v_d = 1'b0;
         cnt_d    = half_d - DIV_W'(1);
         clk_d    = 1'b0;
         fall_d   = clk_q;
      end else begin
         if (cnt_q == '0) begin
            edge_kind = clk_q ? EV_FALL : EV_RISE;
            clk_d     = ~clk_q;
            // pending values are committed only here so the high phase is never cut short
            if (edge_kind == EV_FALL && pend_v_q) begin
               half_d     = pend_half_q;
               dec_d      = pend_dec_q;
               pend_v_d   = 1'b0;
               dec_reload = 1'b1;
            end
            cnt_d = half_d - DIV_W'(1);
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
         rise_d = (edge_kind == EV_RISE);
         fall_d = (edge_kind == EV_FALL);
         if (load) begin
            pend_half_d = half_in_nz;
            pend_dec_d  = dec_in_nz;
            pend_v_d    = 1'b1;
         end
      end
      dec_rel_val = dec_d - DEC_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         half_q      <= DIV_W'(DEF_HALF);
         dec_q       <= DEC_W'(DEF_DEC);
         pend_half_q <= '0;
         pend_dec_q  <= '0;
         pend_v_q    <= 1'b0;
         cnt_q       <= DIV_W'(DEF_HALF - 1);
         clk_q       <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         act_q       <= 1'b0;
      end else begin
         half_q      <= half_d;
         dec_q       <= dec_d;
         pend_half_q <= pend_half_d;
         pend_dec_q  <= pend_dec_d;
         pend_v_q    <= pend_v_d;
         cnt_q       <= cnt_d;
         clk_q       <= clk_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         act_q       <= en;
      end
   end

   mic_rise_counter #(
      .DEC_W   (DEC_W),
      .RST_VAL (DEF_DEC - 1)
   ) u_rise_counter (
      .clk        (clk),
      .reset      (reset),
      .enable     (en),
      .rise       (rise_d),
      .reload     (dec_reload),
      .reload_val (dec_rel_val),
      .sample_stb (sample_stb)
   );

   assign clkout   = clk_q;
   assign rise_stb = rise_q;
   assign fall_stb = fall_q;
   assign active   = act_q;

endmodule

// File: tb/tb_mic_clk_gen.sv
// Scoreboard bench for mic_clk_gen: stimulus queues expected strobe events, a negedge monitor checks them.
module tb_mic_clk_gen;

   localparam int K_RISE   = 0;
   localparam int K_SAMPLE = 1;
   localparam int K_FALL   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] half_in = '0;
   logic [7:0]  dec_in = '0;
   logic        clkout, rise_stb, fall_stb, sample_stb, active;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t expq[$];
   int  cyc = 0;
   int  n_pass = 0;
   int  n_total = 0;

   mic_clk_gen #(
      .DIV_W    (16),
      .DEC_W    (8),
      .DEF_HALF (20),
      .DEF_DEC  (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .load       (load),
      .half_in    (half_in),
      .dec_in     (dec_in),
      .clkout     (clkout),
      .rise_stb   (rise_stb),
      .fall_stb   (fall_stb),
      .sample_stb (sample_stb),
      .active     (active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void push(int kind, int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      expq.push_back(e);
   endfunction

   function automatic void pop_check(int kind);
      ev_t e;
      n_total++;
      if (expq.size() == 0) begin
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, want no event", kind, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind == kind && e.cyc == cyc) n_pass++;
         else $display("FAIL event: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                       kind, cyc, e.kind, e.cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (rise_stb || fall_stb || sample_stb) check("one_edge_strobe", int'(rise_stb & fall_stb), 0);
      if (rise_stb) begin
         pop_check(K_RISE);
         check("clkout_at_rise", int'(clkout), 1);
      end
      if (sample_stb) pop_check(K_SAMPLE);
      if (fall_stb) begin
         pop_check(K_FALL);
         check("clkout_at_fall", int'(clkout), 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(int t);
      while (cyc < t) step();
   endtask

   task automatic do_load(int h, int d);
      half_in = 16'(h);
      dec_in  = 8'(d);
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic stop_and_drain(string name);
      en = 1'b0;
      step();
      step();
      check({name, "_clkout_low"}, int'(clkout), 0);
      check({name, "_queue_empty"}, expq.size(), 0);
   endtask

   initial begin
      int c;
      #3;
      check("rst_clkout", int'(clkout), 0);
      check("rst_rise", int'(rise_stb), 0);
      check("rst_fall", int'(fall_stb), 0);
      check("rst_sample", int'(sample_stb), 0);
      check("rst_active", int'(active), 0);
      step();
      step();
      reset = 1'b1;
      step();
      step();
      check("idle_active", int'(active), 0);

      // defaults: H=20, D=64
      c  = cyc;
      en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         push(K_RISE, c + 20 + 40 * (k - 1));
         if (k == 64) push(K_SAMPLE, c + 20 + 40 * (k - 1));
         push(K_FALL, c + 40 * k);
      end
      step();
      check("active_on", int'(active), 1);
      wait_cyc(c + 2560);
      stop_and_drain("defaults");
      check("active_off", int'(active), 0);

      // zero loads become 1: toggle every cycle, sample every rise
      do_load(0, 0);
      c  = cyc;
      en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         push(K_RISE, c + 2 * k - 1);
         push(K_SAMPLE, c + 2 * k - 1);
         push(K_FALL, c + 2 * k);
      end
      wait_cyc(c + 8);
      stop_and_drain("h1");

      do_load(20, 64);

      // load mid high phase: high stays 20, then period 10
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 20);
      wait_cyc(c + 25);
      do_load(5, 64);
      push(K_FALL, c + 40);
      push(K_RISE, c + 45);
      push(K_FALL, c + 50);
      push(K_RISE, c + 55);
      push(K_FALL, c + 60);
      wait_cyc(c + 60);
      stop_and_drain("midload");

      // en dropped while clkout high
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 5);
      wait_cyc(c + 7);
      en = 1'b0;
      push(K_FALL, c + 8);
      step();
      step();
      step();
      check("drop_high_queue_empty", expq.size(), 0);
      check("drop_high_clkout", int'(clkout), 0);

      // two loads in one period: last wins
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 5);
      wait_cyc(c + 1);
      do_load(8, 64);
      wait_cyc(c + 4);
      do_load(12, 64);
      push(K_FALL, c + 10);
      push(K_RISE, c + 22);
      push(K_FALL, c + 34);
      wait_cyc(c + 34);
      stop_and_drain("twoloads");

      // load coincident with fall toggle: applied at the following fall
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 12);
      push(K_FALL, c + 24);
      wait_cyc(c + 23);
      do_load(3, 64);
      push(K_RISE, c + 36);
      push(K_FALL, c + 48);
      push(K_RISE, c + 51);
      push(K_FALL, c + 54);
      wait_cyc(c + 54);
      stop_and_drain("samecycle");

      // asynchronous reset mid-period restores H=20
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 3);
      wait_cyc(c + 4);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_clkout", int'(clkout), 0);
      check("async_rst_active", int'(active), 0);
      check("async_rst_rise", int'(rise_stb), 0);
      check("async_rst_fall", int'(fall_stb), 0);
      check("async_rst_sample", int'(sample_stb), 0);
      en = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      c  = cyc;
      en = 1'b1;
      push(K_RISE, c + 20);
      push(K_FALL, c + 40);
      wait_cyc(c + 40);
      stop_and_drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mic_clk_gen.md
MIC_CLK_GEN -- requirements
Module: mic_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the half-period register.
REQ-002 SHALL have parameter DEC_W, default 8, width of the decimation register.
REQ-003 SHALL have parameter DEF_HALF, default 20, half-period in clk cycles after reset (100 MHz -> 2.5 MHz).
REQ-004 SHALL have parameter DEF_DEC, default 64, mic-clock rises per sample strobe after reset.
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  run enable; low holds clkout at 0.
REQ-008 SHALL have port load  input  1  one-cycle request to capture half_in and dec_in.
REQ-009 SHALL have port half_in  input  DIV_W  requested half-period in clk cycles.
REQ-010 SHALL have port dec_in  input  DEC_W  requested decimation ratio.
REQ-011 SHALL have port clkout  output  1  registered microphone clock, 50% duty.
REQ-012 SHALL have port rise_stb  output  1  one-cycle pulse in the cycle clkout becomes 1.
REQ-013 SHALL have port fall_stb  output  1  one-cycle pulse in the cycle clkout becomes 0.
REQ-014 SHALL have port sample_stb  output  1  one-cycle pulse on every dec-th rise_stb.
REQ-015 SHALL have port active  output  1  registered copy of en (status LED).

Function
REQ-016 SHALL hold active shadow registers H (DIV_W) and D (DEC_W); value 0 loaded into either SHALL be stored as 1.
REQ-017 While en=0: clkout=0, strobes=0, down-counter=H-1, rise counter=D-1; load SHALL update H/D immediately.
REQ-018 While en=1: each clk, if counter==0 then toggle clkout and reload H-1, else decrement; clkout period = 2H clk cycles.
REQ-019 First rising clkout SHALL occur on the H-th clk edge at which en=1 is sampled.
REQ-020 rise_stb/fall_stb SHALL be registered, asserted in the same cycle as the corresponding clkout change, never both in one cycle.
REQ-021 Rise counter SHALL decrement on each rise; at 0 SHALL assert sample_stb with that rise_stb and reload D-1.
REQ-022 load while en=1 SHALL capture into pending registers; pending SHALL be applied only at the next fall toggle (glitch-free), both counters reloaded from new values then.
REQ-023 A second load before application SHALL overwrite pending values; last one wins.
REQ-024 load and fall toggle in the same cycle: toggle SHALL use old values, new values applied at the following fall.
REQ-025 en falling mid-period SHALL force clkout=0 on the next edge; fall_stb SHALL pulse only if clkout was 1.
REQ-026 Counter SHALL never wrap: H=1 gives clkout toggling every cycle (period 2).

Reset
REQ-027 On reset=0, asynchronously: clkout=0, rise_stb=0, fall_stb=0, sample_stb=0, active=0, H=DEF_HALF, D=DEF_DEC, pending cleared, counters reloaded.
REQ-028 Reset deassertion SHALL take effect on the next clk edge with no spurious strobes.

Structure
REQ-029 DEF_HALF, DEF_DEC and width defaults SHALL live in shared package mic_pkg, reused by PDM decimator blocks.
REQ-030 The decimation counter SHALL be a sub-module mic_rise_counter (inputs rise, reload value, enable; output sample_stb).

Verification
REQ-031 Reset, en=1, defaults -> clkout period 40 cycles, first rise on 20th edge, sample_stb every 64 rises (2560 cycles).
REQ-032 load half_in=0, dec_in=0 with en=0, then en=1 -> clkout toggles every cycle, sample_stb with every rise_stb.
REQ-033 load half_in=5 mid high phase at H=20 -> high phase stays 20, low phase after next fall is 5, period 10 thereafter.
REQ-034 Two loads (half 8 then 12) within one period -> only 12 applied at next fall.
REQ-035 en dropped while clkout=1 -> clkout 0 next edge, one fall_stb; dropped while 0 -> no fall_stb.
REQ-036 reset asserted mid-period -> outputs 0 immediately without clk, H/D back to 20/64.
